// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;
   typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0] rf_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-register tracking and sticky protocol-error detection.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic             issue_valid_i,
   input  logic [AW-1:0]    issue_rd_i,
   input  logic             wb_valid_i,
   input  logic [AW-1:0]    wb_rd_i,
   output logic [NREGS-1:0] busy_vec_o,
   output logic             err_o
);
   logic [NREGS-1:0] busy_q, busy_d;
   logic             err_q, err_d;
   logic             wb_hit, iss_hit;

   // x0 writes/issues are no-ops, so they can never be a protocol error.
   assign wb_hit  = run_i && wb_valid_i && (wb_rd_i != '0);
   assign iss_hit = run_i && issue_valid_i && (issue_rd_i != '0);

   always_comb begin
      busy_d = busy_q;
      err_d  = err_q;
      if (wb_hit) begin
         if (!busy_q[wb_rd_i]) err_d = 1'b1;
         busy_d[wb_rd_i] = 1'b0;
      end
      // Issue applied after wb so a same-cycle reallocation leaves the bit set.
      if (iss_hit) begin
         if (busy_q[issue_rd_i] && !(wb_hit && (wb_rd_i == issue_rd_i))) err_d = 1'b1;
         busy_d[issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_vec_o = busy_q;
   assign err_o      = err_q;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-back bypass, scoreboard and
// post-reset clearing sequence (array itself carries no reset).
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      init_done,
   input  logic [NRD-1:0][AW-1:0]    rd_addr,
   output logic [NRD-1:0][XLEN-1:0]  rd_data,
   output logic [NRD-1:0]            rd_ready,
   input  logic                      issue_valid,
   input  logic [AW-1:0]             issue_rd,
   input  logic                      wb_valid,
   input  logic [AW-1:0]             wb_rd,
   input  logic [XLEN-1:0]           wb_data,
   output logic [NREGS-1:0]          busy_vec,
   output logic                      err
);
   rf_state_e        state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [XLEN-1:0]  wr_data;
   logic [XLEN-1:0]  mem_q [NREGS];
   logic             run;

   assign run       = (state_q == RF_RUN);
   assign init_done = run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RF_INIT;
         ptr_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Single array write port, shared by the clearing sweep and write-back.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wr_en   = 1'b0;
      wr_addr = ptr_q;
      wr_data = '0;
      case (state_q)
         RF_INIT: begin
            wr_en = 1'b1;
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(NREGS - 1)) state_d = RF_RUN;
         end
         RF_RUN: begin
            if (wb_valid && (wb_rd != '0)) begin
               wr_en   = 1'b1;
               wr_addr = wb_rd;
               wr_data = wb_data;
            end
         end
         default: state_d = RF_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   regfile_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk           (clk),
      .rst           (rst),
      .run_i         (run),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .wb_valid_i    (wb_valid),
      .wb_rd_i       (wb_rd),
      .busy_vec_o    (busy_vec),
      .err_o         (err)
   );

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic byp;
      assign byp         = wb_valid && (wb_rd == rd_addr[i]);
      assign rd_data[i]  = (!run || (rd_addr[i] == '0)) ? '0 :
                           byp ? wb_data : mem_q[rd_addr[i]];
      assign rd_ready[i] = run && ((rd_addr[i] == '0) || byp || !busy_vec[rd_addr[i]]);
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: reference model compared every cycle plus directed
// literal checks; a second NREGS=16/NRD=3 instance covers the small build.
module tb_regfile_sb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Default build
   logic [1:0][4:0]   rd_addr = '0;
   logic [1:0][31:0]  rd_data;
   logic [1:0]        rd_ready;
   logic              issue_valid = 1'b0, wb_valid = 1'b0;
   logic [4:0]        issue_rd = '0, wb_rd = '0;
   logic [31:0]       wb_data = '0;
   logic [31:0]       busy_vec;
   logic              err, init_done;

   regfile_sb dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy_vec(busy_vec), .err(err));

   // Small build: NREGS=16, NRD=3
   logic [2:0][3:0]   rd_addr16 = '0;
   logic [2:0][31:0]  rd_data16;
   logic [2:0]        rd_ready16;
   logic              issue_valid16 = 1'b0, wb_valid16 = 1'b0;
   logic [3:0]        issue_rd16 = '0, wb_rd16 = '0;
   logic [31:0]       wb_data16 = '0;
   logic [15:0]       busy_vec16;
   logic              err16, init_done16;

   regfile_sb #(.XLEN(32), .NREGS(16), .NRD(3)) dut16 (
      .clk(clk), .rst(rst), .init_done(init_done16),
      .rd_addr(rd_addr16), .rd_data(rd_data16), .rd_ready(rd_ready16),
      .issue_valid(issue_valid16), .issue_rd(issue_rd16),
      .wb_valid(wb_valid16), .wb_rd(wb_rd16), .wb_data(wb_data16),
      .busy_vec(busy_vec16), .err(err16));

   int vecs = 0;
   int miss = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_regs [32];
   bit   [31:0] m_busy;
   bit          m_err;
   int          m_cyc;   // edges seen since reset released

   function automatic bit m_done();
      return m_cyc >= 31;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = '0;
         m_err  = 1'b0;
         m_cyc  = 0;
         for (int r = 0; r < 32; r++) m_regs[r] = '0;
      end else if (!m_done()) begin
         m_cyc++;
      end else begin
         bit [31:0] old_busy;
         old_busy = m_busy;
         if (wb_valid && wb_rd != 0) begin
            if (!old_busy[wb_rd]) m_err = 1'b1;
            m_regs[wb_rd] = wb_data;
            m_busy[wb_rd] = 1'b0;
         end
         if (issue_valid && issue_rd != 0) begin
            if (old_busy[issue_rd] && !(wb_valid && wb_rd == issue_rd)) m_err = 1'b1;
            m_busy[issue_rd] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) begin
         logic [31:0] ed;
         logic        er;
         if (!m_done())                          begin ed = '0;              er = 1'b0; end
         else if (rd_addr[p] == 0)               begin ed = '0;              er = 1'b1; end
         else if (wb_valid && wb_rd == rd_addr[p]) begin ed = wb_data;       er = 1'b1; end
         else begin ed = m_regs[rd_addr[p]]; er = !m_busy[rd_addr[p]]; end
         chk($sformatf("model rd_data[%0d]", p), 64'(rd_data[p]), 64'(ed));
         chk($sformatf("model rd_ready[%0d]", p), 64'(rd_ready[p]), 64'(er));
      end
      chk("model busy_vec", 64'(busy_vec), 64'(m_busy));
      chk("model err", 64'(err), 64'(m_err));
      chk("model init_done", 64'(init_done), 64'(m_done()));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0; wb_valid = 1'b0; issue_rd = '0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic reset_and_wait_init();
      idle();
      rst = 1'b1;
      tick(); tick();
      @(negedge clk);
      rst = 1'b0;
      repeat (31) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      @(negedge clk);
      chk("reset init_done", 64'(init_done), 64'd0);
      chk("reset busy_vec", 64'(busy_vec), 64'd0);
      chk("reset err", 64'(err), 64'd0);
      rst = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("init_done after 30 edges", 64'(init_done), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("init_done after 31 edges", 64'(init_done), 64'd1);
      chk("small init_done after 31 edges", 64'(init_done16), 64'd1);
      tick();

      // All entries cleared and ready
      for (int r = 0; r < 32; r++) begin
         rd_addr[0] = 5'(r);
         rd_addr[1] = 5'(31 - r);
         @(negedge clk);
         chk("cleared rd_data0", 64'(rd_data[0]), 64'd0);
         chk("cleared rd_ready", 64'(rd_ready), 64'h3);
         tick();
      end

      // issue x5, bypass, then array
      issue_valid = 1'b1; issue_rd = 5'd5; rd_addr[0] = 5'd5;
      tick();
      issue_valid = 1'b0;
      @(negedge clk);
      chk("x5 pending ready", 64'(rd_ready[0]), 64'd0);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("x5 bypass data", 64'(rd_data[0]), 64'hDEADBEEF);
      chk("x5 bypass ready", 64'(rd_ready[0]), 64'd1);
      tick();
      idle();
      @(negedge clk);
      chk("x5 array data", 64'(rd_data[0]), 64'hDEADBEEF);
      tick();

      // x7 overwritten with zero
      issue_valid = 1'b1; issue_rd = 5'd7; tick(); idle();
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hAAAA5555; tick(); idle();
      issue_valid = 1'b1; issue_rd = 5'd7; tick(); idle();
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h0; tick(); idle();
      rd_addr[1] = 5'd7;
      @(negedge clk);
      chk("x7 zero data", 64'(rd_data[1]), 64'd0);
      chk("x7 ready", 64'(rd_ready[1]), 64'd1);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; rd_addr[1] = 5'd0; tick(); idle();
      @(negedge clk);
      chk("x0 data", 64'(rd_data[1]), 64'd0);
      tick();

      // Same-cycle issue+wb, then WAW
      issue_valid = 1'b1; issue_rd = 5'd3; tick(); idle();
      issue_valid = 1'b1; issue_rd = 5'd3; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
      tick(); idle();
      @(negedge clk);
      chk("x3 busy kept", 64'(busy_vec[3]), 64'd1);
      chk("x3 no err", 64'(err), 64'd0);
      tick();
      issue_valid = 1'b1; issue_rd = 5'd3; tick(); idle();
      tick(); tick();
      @(negedge clk);
      chk("WAW err sticky", 64'(err), 64'd1);
      tick();

      // Spurious wb, then mid-run reset
      reset_and_wait_init();
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99; tick(); idle();
      @(negedge clk);
      chk("spurious wb err", 64'(err), 64'd1);
      issue_valid = 1'b1; issue_rd = 5'd12; tick(); idle();
      rst = 1'b1;
      #1;
      chk("async rst err", 64'(err), 64'd0);
      chk("async rst busy", 64'(busy_vec), 64'd0);
      chk("async rst init_done", 64'(init_done), 64'd0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      repeat (31) @(posedge clk);
      #1;

      // Randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         idle();
         if ($urandom_range(399) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            continue;
         end
         rd_addr[0] = 5'($urandom);
         rd_addr[1] = 5'($urandom);
         if ($urandom_range(9) < 4) begin
            issue_valid = 1'b1;
            issue_rd = 5'($urandom);
         end
         if ($urandom_range(9) < 5) begin
            int s;
            wb_valid = 1'b1;
            wb_data  = $urandom;
            s = int'($urandom_range(31));
            wb_rd = 5'(s);
            if ($urandom_range(3) != 0)
               for (int k = 0; k < 32; k++)
                  if (m_busy[(s + k) % 32]) begin wb_rd = 5'((s + k) % 32); break; end
            if ($urandom_range(3) == 0) rd_addr[$urandom_range(1)] = wb_rd;
         end
         tick();
      end
      idle();

      // Small build: 15-edge init and three concurrent distinct reads
      rst = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      chk("small init_done after 14 edges", 64'(init_done16), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("small init_done after 15 edges", 64'(init_done16), 64'd1);
      tick();
      for (int r = 1; r < 16; r++) begin
         issue_valid16 = 1'b1; issue_rd16 = 4'(r); tick();
         issue_valid16 = 1'b0;
         wb_valid16 = 1'b1; wb_rd16 = 4'(r); wb_data16 = 32'hC0DE0000 + 32'(r * 17); tick();
         wb_valid16 = 1'b0;
      end
      for (int r = 1; r <= 5; r++) begin
         rd_addr16[0] = 4'(r);
         rd_addr16[1] = 4'(r + 5);
         rd_addr16[2] = 4'(r + 10);
         @(negedge clk);
         for (int p = 0; p < 3; p++)
            chk($sformatf("small port%0d data", p), 64'(rd_data16[p]),
                64'(32'hC0DE0000 + 32'((r + 5 * p) * 17)));
         chk("small ready", 64'(rd_ready16), 64'h7);
         tick();
      end
      chk("small err clean", 64'(err16), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
